// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle for spi_regfile_periph.
//   sclk    : SPI clock, idle low, driven by the host
//   ncs     : chip select, active-low, driven by the host
//   copi    : host-to-peripheral data
//   cipo    : peripheral-to-host data (readback)
//   cipo_oe : pad output enable for cipo
// Modports: master = SPI host side, slave = peripheral side.
interface spi_regfile_periph_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral giving the host write (and optionally read) access
// to NUM_REGS registers of DATA_W bits each.
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.
// Registers change only when a complete, correctly sized frame ends, so a
// frame is atomic.
//
// Optional feature: define SPI_READBACK_EN to drive the addressed register
// on cipo during the data phase of read frames.
//
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   spi           : SPI pins (slave modport of spi_regfile_periph_if)
//   regs_out      : flat register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse      : one-clk strobe during the commit of a write
//   wr_addr       : address of the last committed write
//   frame_err_cnt : saturating count of frames with the wrong bit count
module spi_regfile_periph #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_periph_if.slave          spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   frame_err_cnt
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int SET_W     = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_LEN + 1);
  localparam logic [SET_W-1:0]  SETTLE     = SET_W'(SYNC_STAGES + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_IDLE} state_t;

  state_t state_q, state_d;

  // ---------------- synchronisers and edge detect ----------------
  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, ncs_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '1;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  // The ncs chain resets high, so a host already holding ncs low when reset
  // releases would look like a fresh falling edge. Until the chain and its
  // delay FF hold real pin values, a low ncs sends the FSM to WAIT_IDLE.
  logic [SET_W-1:0] settle_q;
  logic             settled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                settle_q <= '0;
    else if (settle_q != SETTLE) settle_q <= settle_q + 1'b1;
  end

  assign settled = (settle_q == SETTLE);

  // ---------------- frame capture ----------------
  logic [FRAME_LEN-1:0] shreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 frame_rw;
  logic [ADDR_W-1:0]    frame_addr;
  logic [DATA_W-1:0]    frame_data;
  logic                 addr_ok;
  logic                 start, do_write, do_err;

  assign frame_rw   = shreg_q[FRAME_LEN-1];
  assign frame_addr = shreg_q[FRAME_LEN-2 -: ADDR_W];
  assign frame_data = shreg_q[DATA_W-1:0];
  assign addr_ok    = ({1'b0, frame_addr} < NUM_REGS_W);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    do_write = 1'b0;
    do_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Level test on synchronised ncs: a select that dropped while we
        // were still in COMMIT is picked up here one clk later.
        if (!ncs_s) begin
          if (settled) begin
            state_d = SHIFT;
            start   = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      SHIFT: begin
        if (ncs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q != CNT_FULL)       do_err   = 1'b1;
        else if (frame_rw && addr_ok) do_write = 1'b1;
      end
      WAIT_IDLE: begin
        if (ncs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_pulse = do_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == SHIFT && sclk_rise) begin
      shreg_q <= {shreg_q[FRAME_LEN-2:0], copi_s};
      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------- register bank and status ----------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: the bank is a handful of config flops, not a RAM, so it is reset
  // along with everything else and comes up at a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_addr       <= '0;
      frame_err_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (do_write && frame_addr == ADDR_W'(k)) regs_q[k] <= frame_data;
      end
      if (do_write) wr_addr <= frame_addr;
      if (do_err && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  // ---------------- readback ----------------
`ifdef SPI_READBACK_EN
  logic                 sclk_fall;
  logic [FRAME_LEN-1:0] shreg_next;
  logic [DATA_W-1:0]    rd_data;
  logic [DATA_W-1:0]    tx_q;
  logic                 tx_load, tx_shift;

  assign sclk_fall  = ~sclk_s & sclk_d;
  // Header as it will look after the edge being processed this clk.
  assign shreg_next = {shreg_q[FRAME_LEN-2:0], copi_s};
  assign tx_load    = (state_q == SHIFT) && sclk_rise &&
                      (cnt_q == CNT_W'(ADDR_W)) && !shreg_next[ADDR_W];
  // The falling edge right after the header leaves the MSB on cipo for the
  // first data-phase rising edge; later falling edges advance the shifter.
  assign tx_shift   = (state_q == SHIFT) && sclk_fall && (cnt_q > CNT_W'(1 + ADDR_W));

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (shreg_next[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tx_q <= '0;
    else if (start)    tx_q <= '0;
    else if (tx_load)  tx_q <= rd_data;
    else if (tx_shift) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
  end

  assign spi.cipo    = tx_q[DATA_W-1] & ~ncs_s;
  assign spi.cipo_oe = ~ncs_s;
`else
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed self-checking bench for spi_regfile_periph (default parameters:
// DATA_W=8, ADDR_W=7, NUM_REGS=5, SYNC_STAGES=2). The SPI host is modelled
// with sclk period 16 clk; inputs change on clk falling edges and outputs
// are sampled there too.
module tb_spi_regfile_periph;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] regs_out;
  logic        wr_pulse;
  logic [6:0]  wr_addr;
  logic [7:0]  frame_err_cnt;

  spi_regfile_periph_if bus ();

  spi_regfile_periph dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (bus),
    .regs_out      (regs_out),
    .wr_pulse      (wr_pulse),
    .wr_addr       (wr_addr),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          pulse_cnt = 0;
  int          pulse_base;
  logic [63:0] rx_bits;
  logic        oe_seen;

  always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.ncs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.ncs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Send w[n-1:0] MSB first; cipo is captured at each sclk rising edge.
  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.copi = w[i];
      repeat (8) @(negedge clk);
      bus.sclk = 1'b1;
      rx_bits  = {rx_bits[62:0], bus.cipo};
      oe_seen  = bus.cipo_oe;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic send(input logic [63:0] w, input int n);
    rx_bits = '0;
    cs_low();
    shift_bits(w, n);
    cs_high();
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.sclk = 1'b0;
    bus.ncs  = 1'b1;
    bus.copi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_regs", regs_out, 40'h0);
    check("reset_pulse", wr_pulse, 1'b0);
    check("reset_cipo", bus.cipo, 1'b0);
    check("reset_oe", bus.cipo_oe, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_err", frame_err_cnt, 8'd0);
    check("idle_addr", wr_addr, 7'd0);

    // Write reg2 = 0xA5.
    pulse_base = pulse_cnt;
    send(64'h82A5, 16);
    check("wr2_regs", regs_out, 40'h00_00_A5_00_00);
    check("wr2_pulse_len", pulse_cnt - pulse_base, 1);
    check("wr2_addr", wr_addr, 7'd2);
    check("wr2_err", frame_err_cnt, 8'd0);

    // Write to out-of-range address 5: silently dropped.
    pulse_base = pulse_cnt;
    send(64'h85FF, 16);
    check("oor_regs", regs_out, 40'h00_00_A5_00_00);
    check("oor_pulse", pulse_cnt - pulse_base, 0);
    check("oor_err", frame_err_cnt, 8'd0);
    check("oor_addr", wr_addr, 7'd2);

    // 15-bit and 17-bit frames carrying write reg0 = 0x3C.
    send(64'h803C >> 1, 15);
    check("short_err", frame_err_cnt, 8'd1);
    send(64'h803C << 1, 17);
    check("long_err", frame_err_cnt, 8'd2);
    check("len_regs", regs_out, 40'h00_00_A5_00_00);

    // Write reg3 = 0x96, then read it back.
    send(64'h8396, 16);
    check("wr3_regs", regs_out, 40'h00_96_A5_00_00);
    pulse_base = pulse_cnt;
    send(64'h0300, 16);
`ifdef SPI_READBACK_EN
    check("rd3_data", rx_bits[7:0], 8'h96);
    check("rd3_hdr", rx_bits[15:8], 8'h00);
    check("rd3_oe", oe_seen, 1'b1);
`else
    check("rd3_data", rx_bits[15:0], 16'h0000);
    check("rd3_oe", oe_seen, 1'b0);
`endif
    check("rd3_regs", regs_out, 40'h00_96_A5_00_00);
    check("rd3_pulse", pulse_cnt - pulse_base, 0);
    check("rd3_err", frame_err_cnt, 8'd2);
    check("idle_cipo", bus.cipo, 1'b0);

    // Reset after 9 bits with ncs held low, then finish the frame.
    pulse_base = pulse_cnt;
    rx_bits = '0;
    cs_low();
    shift_bits(64'h8111 >> 7, 9);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    shift_bits(64'h8111 & 64'h7F, 7);
    cs_high();
    check("mid_rst_regs", regs_out, 40'h0);
    check("mid_rst_err", frame_err_cnt, 8'd0);
    check("mid_rst_pulse", pulse_cnt - pulse_base, 0);
    send(64'h8111, 16);
    check("post_rst_regs", regs_out, 40'h00_00_00_11_00);
    check("post_rst_addr", wr_addr, 7'd1);
    check("post_rst_pulse", pulse_cnt - pulse_base, 1);

    // Error counter saturation with zero-bit frames.
    for (int i = 0; i < 254; i++) begin
      cs_low();
      cs_high();
    end
    check("err_254", frame_err_cnt, 8'd254);
    for (int i = 0; i < 46; i++) begin
      cs_low();
      cs_high();
    end
    check("err_sat", frame_err_cnt, 8'd255);
    check("sat_regs", regs_out, 40'h00_00_00_11_00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
